core8_oci_trace_capture: RTL and testbench

- Parametrised successor to the per-core OCI test-bench trace sink.
- Captures debug/trace words (dct_buffer with its dct_count) from a Core8 CPU OCI into a show-ahead FIFO and exposes them to a host-side reader.
- Tracks overflow and dropped words.
- On test_ending, stops capture, drains the FIFO to the reader, then asserts test_has_ended.

---
 rtl/core8_oci_trace_capture.sv | 143 ++++++++++++++
 tb/tb_core8_oci_trace_capture.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/core8_oci_trace_capture.sv
// core8_oci_trace_capture
// Trace sink for a Core8 CPU OCI. Qualifying debug/trace words are captured
// into a show-ahead FIFO for a host-side reader. Words that arrive while the
// FIFO is full are counted as dropped. When test_ending is seen, capture stops,
// the FIFO drains to the reader, and the block then reports test_has_ended.

module core8_oci_trace_capture #(
    parameter int DATA_W = 30,
    parameter int CNT_W  = 4,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int DROP_W = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [DATA_W-1:0] i_dct_buffer,
    input  logic [CNT_W-1:0]  i_dct_count,
    input  logic              i_dct_valid,
    input  logic              i_test_ending,
    input  logic              i_rd_ready,
    output logic              o_rd_valid,
    output logic [DATA_W-1:0] o_rd_data,
    output logic [CNT_W-1:0]  o_rd_count,
    output logic [ADDR_W:0]   o_fill_level,
    output logic              o_overflow,
    output logic [DROP_W-1:0] o_dropped_count,
    output logic              o_test_has_ended
);

    localparam int ENTRY_W = DATA_W + CNT_W;
    localparam logic [ADDR_W:0] FULL_LEVEL = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        CAPTURE = 2'd0,
        DRAIN   = 2'd1,
        ENDED   = 2'd2
    } state_t;

    state_t r_state;
    state_t w_stateNext;

    logic [ENTRY_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0]  r_wrPtr;
    logic [ADDR_W-1:0]  r_rdPtr;
    logic [ADDR_W:0]    r_fillLevel;
    logic               r_overflow;
    logic [DROP_W-1:0]  r_droppedCount;

    logic               w_qualified;
    logic               w_full;
    logic               w_pop;
    logic               w_push;
    logic               w_drop;
    logic [ENTRY_W-1:0] w_head;

    // Head entry is shown ahead; the reader sees it as soon as it is stored.
    always_comb begin
        w_head      = r_mem[r_rdPtr];
        o_rd_valid  = (r_fillLevel != '0) && (r_state != ENDED);
        w_qualified = i_dct_valid && (i_dct_count != '0);
        w_full      = (r_fillLevel == FULL_LEVEL);
        w_pop       = o_rd_valid && i_rd_ready;
        w_push      = (r_state == CAPTURE) && w_qualified && (!w_full || w_pop);
        w_drop      = (r_state == CAPTURE) && w_qualified && w_full && !w_pop;
    end

    assign o_rd_data        = w_head[DATA_W-1:0];
    assign o_rd_count       = w_head[ENTRY_W-1:DATA_W];
    assign o_fill_level     = r_fillLevel;
    assign o_overflow       = r_overflow;
    assign o_dropped_count  = r_droppedCount;
    assign o_test_has_ended = (r_state == ENDED);

    // Capture state register; ENDED is only left through reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= CAPTURE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next state: stop capture on test_ending, finish once the last entry leaves.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            CAPTURE: begin
                if (i_test_ending) begin
                    w_stateNext = DRAIN;
                end
            end
            DRAIN: begin
                if ((r_fillLevel == '0) ||
                    ((r_fillLevel == (ADDR_W + 1)'(1)) && w_pop)) begin
                    w_stateNext = ENDED;
                end
            end
            ENDED: begin
                w_stateNext = ENDED;
            end
            default: begin
                w_stateNext = CAPTURE;
            end
        endcase
    end

    // Storage array holds {count, word}; contents need no reset since fill level gates them.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= {i_dct_count, i_dct_buffer};
        end
    end

    // Pointers, occupancy and drop bookkeeping; reset discards everything at once.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wrPtr        <= '0;
            r_rdPtr        <= '0;
            r_fillLevel    <= '0;
            r_overflow     <= 1'b0;
            r_droppedCount <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + ADDR_W'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + ADDR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_fillLevel <= r_fillLevel + (ADDR_W + 1)'(1);
                2'b01:   r_fillLevel <= r_fillLevel - (ADDR_W + 1)'(1);
                default: r_fillLevel <= r_fillLevel;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_droppedCount != '1) begin
                    r_droppedCount <= r_droppedCount + DROP_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_core8_oci_trace_capture.sv
// tb_core8_oci_trace_capture
// Directed scoreboard bench: stimulus pushes every word it expects to be
// stored into a queue; a monitor pops and compares whenever a read handshake
// is about to complete.

module tb_core8_oci_trace_capture;

    localparam int DATA_W = 30;
    localparam int CNT_W  = 4;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
    localparam int DROP_W = 16;

    logic              clk;
    logic              reset;
    logic [DATA_W-1:0] dctBuffer;
    logic [CNT_W-1:0]  dctCount;
    logic              dctValid;
    logic              testEnding;
    logic              rdReady;
    logic              rdValid;
    logic [DATA_W-1:0] rdData;
    logic [CNT_W-1:0]  rdCount;
    logic [ADDR_W:0]   fillLevel;
    logic              overflow;
    logic [DROP_W-1:0] droppedCount;
    logic              testHasEnded;

    logic [CNT_W+DATA_W-1:0] expectedQ [$];
    int checkCount = 0;
    int passCount  = 0;

    core8_oci_trace_capture #(
        .DATA_W(DATA_W), .CNT_W(CNT_W), .DEPTH(DEPTH),
        .ADDR_W(ADDR_W), .DROP_W(DROP_W)
    ) dut (
        .i_clk            (clk),
        .i_reset          (reset),
        .i_dct_buffer     (dctBuffer),
        .i_dct_count      (dctCount),
        .i_dct_valid      (dctValid),
        .i_test_ending    (testEnding),
        .i_rd_ready       (rdReady),
        .o_rd_valid       (rdValid),
        .o_rd_data        (rdData),
        .o_rd_count       (rdCount),
        .o_fill_level     (fillLevel),
        .o_overflow       (overflow),
        .o_dropped_count  (droppedCount),
        .o_test_has_ended (testHasEnded)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // One clock of stimulus; inputs change 1 ns after a rising edge and the
    // task returns 1 ns after the edge that consumed them.
    task automatic applyStimulus(input logic valid, input logic [CNT_W-1:0] count,
                                 input logic [DATA_W-1:0] data, input logic ready,
                                 input logic ending, input bit store);
        dctValid   = valid;
        dctCount   = count;
        dctBuffer  = data;
        rdReady    = ready;
        testEnding = ending;
        if (store) begin
            expectedQ.push_back({count, data});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        reset      = 1'b1;
        dctValid   = 1'b0;
        dctCount   = '0;
        dctBuffer  = '0;
        rdReady    = 1'b0;
        testEnding = 1'b0;
        expectedQ.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Monitor: a handshake seen mid-cycle completes on the next rising edge.
    initial begin
        logic [CNT_W+DATA_W-1:0] exp;
        forever begin
            @(negedge clk);
            if (!reset && rdValid === 1'b1 && rdReady === 1'b1) begin
                checkCount++;
                if (expectedQ.size() == 0) begin
                    $display("[TB] FAIL readUnexpected: got count=%0d data=0x%0h, expected no entry",
                             rdCount, rdData);
                end else begin
                    exp = expectedQ.pop_front();
                    if ({rdCount, rdData} === exp) begin
                        passCount++;
                    end else begin
                        $display("[TB] FAIL readData: got count=%0d data=0x%0h, expected count=%0d data=0x%0h",
                                 rdCount, rdData, exp[CNT_W+DATA_W-1:DATA_W], exp[DATA_W-1:0]);
                    end
                end
            end
        end
    end

    initial begin
        logic [CNT_W-1:0] c;
        reset      = 1'b1;
        dctValid   = 1'b0;
        dctCount   = '0;
        dctBuffer  = '0;
        rdReady    = 1'b0;
        testEnding = 1'b0;
        @(posedge clk);
        doReset();

        checkOutput("resetFill", 32'(fillLevel), 32'd0);
        checkOutput("resetRdValid", 32'(rdValid), 32'd0);
        checkOutput("resetOverflow", 32'(overflow), 32'd0);
        checkOutput("resetDropped", 32'(droppedCount), 32'd0);
        checkOutput("resetEnded", 32'(testHasEnded), 32'd0);

        // Basic order
        applyStimulus(1'b1, 4'd1,  30'h0000001,  1'b0, 1'b0, 1'b1);
        checkOutput("firstVisible", 32'(rdValid), 32'd1);
        applyStimulus(1'b1, 4'd4,  30'h2AAAAAA,  1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 4'd15, 30'h3FFFFFFF, 1'b0, 1'b0, 1'b1);
        checkOutput("basicFill3", 32'(fillLevel), 32'd3);
        repeat (3) applyStimulus(1'b0, 4'd0, 30'h0, 1'b1, 1'b0, 1'b0);
        checkOutput("basicFill0", 32'(fillLevel), 32'd0);
        checkOutput("basicRdValid0", 32'(rdValid), 32'd0);

        // Zero-count filter
        repeat (5) applyStimulus(1'b1, 4'd0, 30'h1234567, 1'b0, 1'b0, 1'b0);
        checkOutput("zeroFill", 32'(fillLevel), 32'd0);
        checkOutput("zeroOverflow", 32'(overflow), 32'd0);
        checkOutput("zeroDropped", 32'(droppedCount), 32'd0);

        // Overflow: 20 words, only the first 16 fit
        for (int i = 0; i < 20; i++) begin
            c = 4'((i % 15) + 1);
            applyStimulus(1'b1, c, 30'(32'h100 + i), 1'b0, 1'b0, (i < 16));
        end
        checkOutput("ovfFill", 32'(fillLevel), 32'd16);
        checkOutput("ovfFlag", 32'(overflow), 32'd1);
        checkOutput("ovfDropped", 32'(droppedCount), 32'd4);

        // Full push+pop: occupancy holds at DEPTH, pointers wrap
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 4'd7, 30'(32'h200 + i), 1'b1, 1'b0, 1'b1);
        end
        checkOutput("fullPpFill", 32'(fillLevel), 32'd16);
        checkOutput("fullPpDropped", 32'(droppedCount), 32'd4);
        repeat (16) applyStimulus(1'b0, 4'd0, 30'h0, 1'b1, 1'b0, 1'b0);
        checkOutput("fullPpEmpty", 32'(fillLevel), 32'd0);
        checkOutput("ovfSticky", 32'(overflow), 32'd1);

        // Drain/end with 5 entries
        doReset();
        checkOutput("rstClearsOvf", 32'(overflow), 32'd0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 4'd2, 30'(32'h300 + i), 1'b0, 1'b0, 1'b1);
        end
        applyStimulus(1'b0, 4'd0, 30'h0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 4'd3, 30'h3A, 1'b1, 1'b0, 1'b0);
            checkOutput("drainEnded", 32'(testHasEnded), (i == 4) ? 32'd1 : 32'd0);
        end
        repeat (2) applyStimulus(1'b1, 4'd3, 30'h3B, 1'b1, 1'b0, 1'b0);
        checkOutput("endedRdValid", 32'(rdValid), 32'd0);
        checkOutput("endedSticky", 32'(testHasEnded), 32'd1);
        checkOutput("drainDropped", 32'(droppedCount), 32'd0);
        checkOutput("drainFill", 32'(fillLevel), 32'd0);

        // End with empty FIFO: ended two edges after assertion
        doReset();
        applyStimulus(1'b0, 4'd0, 30'h0, 1'b0, 1'b1, 1'b0);
        checkOutput("emptyEndK", 32'(testHasEnded), 32'd0);
        applyStimulus(1'b0, 4'd0, 30'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("emptyEndK1", 32'(testHasEnded), 32'd1);

        // Reset mid-drain; a push in the test_ending cycle is still stored
        doReset();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 4'd5, 30'(32'h400 + i), 1'b0, 1'b0, 1'b1);
        end
        applyStimulus(1'b1, 4'd6, 30'h4FF, 1'b0, 1'b1, 1'b1);
        checkOutput("endCyclePush", 32'(fillLevel), 32'd4);
        applyStimulus(1'b1, 4'd6, 30'h4FE, 1'b0, 1'b0, 1'b0);
        checkOutput("drainBlocksPush", 32'(fillLevel), 32'd4);
        doReset();
        checkOutput("midRstFill", 32'(fillLevel), 32'd0);
        checkOutput("midRstEnded", 32'(testHasEnded), 32'd0);
        checkOutput("midRstDropped", 32'(droppedCount), 32'd0);
        applyStimulus(1'b1, 4'd9, 30'h5A5A5A5, 1'b0, 1'b0, 1'b1);
        checkOutput("postRstPush", 32'(fillLevel), 32'd1);
        applyStimulus(1'b0, 4'd0, 30'h0, 1'b1, 1'b0, 1'b0);
        checkOutput("postRstPop", 32'(fillLevel), 32'd0);

        @(negedge clk);
        checkOutput("queueEmpty", 32'(expectedQ.size()), 32'd0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
